ce_sc_extract: RTL
==================

// Module: ce_sc_extract
// PURPOSE
//  Used-subcarrier extraction and reordering ahead of the LS stage.
//  - Takes one FFT output symbol in natural bin order (0..N-1).
//  - Drops the DC bin and the guard bins.
//  - Emits the NUSED used subcarriers in ascending frequency order:
//    bins N-H..N-1 first, then bins 1..H, where H = NUSED/2.
//  - Its source side feeds the LS divider.
// PARAMETERS
//  wDataIn   16    sample width, real and imag each (two's complement)
//  wDataOut  16    output width; must equal wDataIn (samples pass through untouched)
//  NUSED     1200  used subcarriers per symbol; must be even, NUSED/2 <= 1024
// PORTS
//  clk           in   1          clock
//  rst_n_sync    in   1          synchronous reset, active low
//  sink_valid    in   1          input beat valid
//  sink_ready    out  1          block accepts input beat
//  sink_error    in   2          ignored
//  sink_sop      in   1          bin 0 of a symbol
//  sink_eop      in   1          bin N-1 of a symbol
//  sink_real     in   wDataIn    FFT bin, real part
//  sink_imag     in   wDataIn    FFT bin, imag part
//  fftpts_in     in   12         N, power of 2
//  source_valid  out  1          output beat valid
//  source_ready  in   1          downstream accepts beat
//  source_error  out  2          always 2'b00
//  source_sop    out  1          first used subcarrier (bin N-H)
//  source_eop    out  1          last used subcarrier (bin H)
//  source_real   out  wDataOut   subcarrier, real part
//  source_imag   out  wDataOut   subcarrier, imag part
//  fftpts_out    out  12         N latched at the accepted input sop
//  frame_err     out  1          one-cycle pulse on a framing error
// BEHAVIOUR
//  Reset values
//  - All outputs 0; state IDLE; counters 0.
//  - sink_ready is 1 in IDLE.
//  Handshake
//  - A beat transfers when valid && ready.
//  - sink_ready = (state != DRAIN) && (!source_valid || source_ready).
//  - The output register holds data and flags while source_valid && !source_ready.
//  Bin counter
//  - bin counts accepted input beats and resets to 0 at sop.
//  - H = NUSED/2.
//  Buffer
//  - Simple dual-port RAM, depth H, width 2*wDataIn.
//  - Read latency 1 clk; registered output.
//  State machine
//  - IDLE -> LOW on an accepted sop.
//    - If fftpts_in <= NUSED: frame_err pulses, the frame is dropped, state stays IDLE.
//  - LOW: bin 0 (DC) is dropped; bins 1..H are written to RAM address bin-1.
//    - Go to SKIP after bin H.
//  - SKIP: bins H+1..N-H-1 are dropped.
//    - Go to PASS after bin N-H-1.
//  - PASS: bins N-H..N-1 go straight to the output register, 1 clk after acceptance.
//    - source_sop is set on bin N-H.
//    - Go to DRAIN after the accepted eop.
//  - DRAIN: RAM addresses 0..H-1 are read out in order.
//    - source_eop is set on address H-1.
//    - Return to IDLE when that beat transfers.
//  Output timing
//  - First output beat appears 1 clk after bin N-H is accepted.
//  - No bubble at the PASS->DRAIN boundary when source_ready stays high (RAM read is prefetched).
//  Framing errors (each pulses frame_err for 1 clk)
//  - sop accepted in LOW/SKIP/PASS: the current frame is abandoned and restarted in LOW.
//    - If the frame was in PASS, the beat in the output register is still delivered with source_eop forced to 1.
//  - eop with bin != N-1 in LOW/SKIP: frame dropped, state goes to IDLE.
//  - eop with bin != N-1 in PASS: state goes to DRAIN; the output frame is short but sop/eop stay correct.
//  - sink_valid without a preceding sop in IDLE: the beat is ignored; no error.
//  Reset mid-frame
//  - Any state returns to IDLE and source_valid drops in the next cycle.
//  - RAM contents are don't-care.
// CONFIGURATION
//  CE_SC_EXTRACT_FRMCNT_EN
//  - Defined: adds output port frame_cnt [15:0].
//    - Increments when a source_eop beat transfers.
//    - Wraps 16'hFFFF -> 0; reset value 0.
//  - Undefined: the port and counter are absent; all other behaviour is identical.
// TESTING
//  1. N=2048, NUSED=1200, input real=bin, imag=-bin, source_ready=1
//     -> 1200 beats: real 1448..2047, then 1..600.
//     -> sop on real=1448, eop on real=600; no gaps.
//  2. Same as 1 with source_ready toggling 1-in-3
//     -> identical output data; sink_ready low in DRAIN and whenever the output is stalled.
//  3. fftpts_in=1024 at sop -> frame_err pulses once; no source_valid for the whole symbol.
//  4. N=2048, eop at bin 1000 (SKIP) -> frame_err pulses, no output.
//     The next good symbol is reproduced exactly as in 1.
//  5. New sop at bin 1800 (PASS) -> frame_err pulses.
//     The beat for bin 1799 is delivered with eop=1.
//     The following symbol is output correctly.
//  6. rst_n_sync low for 1 clk during DRAIN
//     -> source_valid=0 the next cycle; the next symbol is output as in 1.
//     With CE_SC_EXTRACT_FRMCNT_EN defined, frame_cnt=0 after reset and 1 after that symbol.

Source files
------------

// File: rtl/ce_sc_extract.sv
// ce_sc_extract: used-subcarrier extraction and reordering ahead of LS.
// Takes one FFT symbol in bin order (0..N-1), drops DC and guard bins and
// emits NUSED subcarriers as bins N-H..N-1 then 1..H (H = NUSED/2).
// Ports: clk, rst_n_sync (sync, active low)
//   sink_*   : valid/ready input beats, sop on bin 0, eop on bin N-1
//   fftpts_in: N (power of 2), latched to fftpts_out at accepted sop
//   source_* : valid/ready output beats, sop on bin N-H, eop on bin H
//   frame_err: one-cycle pulse on a framing error
// Option CE_SC_EXTRACT_FRMCNT_EN adds frame_cnt[15:0]: a wrapping count
// of transferred source_eop beats.
module ce_sc_extract #(
  parameter int wDataIn  = 16,
  parameter int wDataOut = 16,
  parameter int NUSED    = 1200
) (
  input  logic                clk,
  input  logic                rst_n_sync,
  input  logic                sink_valid,
  output logic                sink_ready,
  input  logic [1:0]          sink_error,
  input  logic                sink_sop,
  input  logic                sink_eop,
  input  logic [wDataIn-1:0]  sink_real,
  input  logic [wDataIn-1:0]  sink_imag,
  input  logic [11:0]         fftpts_in,
  output logic                source_valid,
  input  logic                source_ready,
  output logic [1:0]          source_error,
  output logic                source_sop,
  output logic                source_eop,
  output logic [wDataOut-1:0] source_real,
  output logic [wDataOut-1:0] source_imag,
  output logic [11:0]         fftpts_out,
  output logic                frame_err
`ifdef CE_SC_EXTRACT_FRMCNT_EN
  ,
  output logic [15:0]         frame_cnt
`endif
);

  localparam int H  = NUSED / 2;
  localparam int AW = (H > 1) ? $clog2(H) : 1;
  localparam logic [11:0] HB = 12'(H);
  localparam logic [12:0] NU = 13'(NUSED);
  localparam logic [AW-1:0] ALAST = AW'(H - 1);

  typedef enum logic [2:0] {
    IDLE, LOW, SKIP, PASS, DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [11:0] bin_q, bin_d;
  logic [11:0] n_q, n_d;
  logic [AW-1:0] dptr_q, dptr_d;
  logic drained_q, drained_d;
  logic err_q, err_d;

  logic [2*wDataIn-1:0] mem [H];
  logic [2*wDataIn-1:0] rdata_q;

  logic vld_q, sop_q, eop_q;
  logic [wDataOut-1:0] re_q, im_q;

  logic can_load, acc, n_ok;
  logic wr_en, ld_pass, ld_drain;
  logic restart, drain_last, drain_done;
  logic abort_eop;
  logic [11:0] pass_lo, n_last;
  logic [AW-1:0] wr_addr;

  logic unused_ok;
  assign unused_ok = ^sink_error;

  assign can_load = !vld_q || source_ready;
  assign sink_ready = (state_q != DRAIN) && can_load;
  assign acc = sink_valid && sink_ready;
  assign n_ok = {1'b0, fftpts_in} > NU;

  assign pass_lo = n_q - HB;
  assign n_last = n_q - 12'd1;
  assign wr_addr = AW'(bin_q - 12'd1);

  assign drain_last = dptr_q == ALAST;
  assign ld_drain = (state_q == DRAIN) && can_load && !drained_q;
  assign drain_done = (state_q == DRAIN) && vld_q && source_ready
                      && eop_q && drained_q;

  // A sop restarting a frame in PASS closes the beat now leaving the
  // output register; it transfers on the same edge the sop is taken.
  assign abort_eop = (state_q == PASS) && vld_q && sink_valid && sink_sop;

  always_comb begin
    state_d = state_q;
    err_d = 1'b0;
    wr_en = 1'b0;
    ld_pass = 1'b0;
    restart = 1'b0;
    if (acc && sink_sop) begin
      err_d = (state_q != IDLE) || !n_ok;
      restart = n_ok;
      state_d = n_ok ? LOW : IDLE;
    end else if (acc) begin
      unique case (state_q)
        LOW: begin
          wr_en = 1'b1;
          if (sink_eop) begin
            err_d = 1'b1;
            state_d = IDLE;
          end else if (bin_q == HB) begin
            state_d = SKIP;
          end
        end
        SKIP: begin
          if (sink_eop) begin
            err_d = 1'b1;
            state_d = IDLE;
          end else if (bin_q == pass_lo - 12'd1) begin
            state_d = PASS;
          end
        end
        PASS: begin
          ld_pass = 1'b1;
          if (sink_eop || bin_q == n_last) begin
            err_d = bin_q != n_last;
            state_d = DRAIN;
          end
        end
        default: ;
      endcase
    end
    if (drain_done) state_d = IDLE;
  end

  always_comb begin
    bin_d = bin_q;
    n_d = n_q;
    dptr_d = dptr_q;
    drained_d = drained_q;
    if (acc) bin_d = sink_sop ? 12'd1 : bin_q + 12'd1;
    if (acc && sink_sop) n_d = fftpts_in;
    if (restart) begin
      dptr_d = '0;
      drained_d = 1'b0;
    end else if (ld_drain) begin
      if (drain_last) drained_d = 1'b1;
      else dptr_d = dptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_sync) begin
      state_q <= IDLE;
      bin_q <= '0;
      n_q <= '0;
      dptr_q <= '0;
      drained_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q <= bin_d;
      n_q <= n_d;
      dptr_q <= dptr_d;
      drained_q <= drained_d;
      err_q <= err_d;
    end
  end

  // Read address follows dptr_d so rdata_q already holds the next
  // drain word when DRAIN starts: no bubble after the PASS beats.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {sink_real, sink_imag};
    rdata_q <= mem[dptr_d];
  end

  always_ff @(posedge clk) begin
    if (!rst_n_sync) begin
      vld_q <= 1'b0;
      sop_q <= 1'b0;
      eop_q <= 1'b0;
      re_q <= '0;
      im_q <= '0;
    end else if (can_load) begin
      vld_q <= ld_pass || ld_drain;
      sop_q <= ld_pass && (bin_q == pass_lo);
      eop_q <= ld_drain && drain_last;
      unique case (1'b1)
        ld_pass: begin
          re_q <= sink_real;
          im_q <= sink_imag;
        end
        ld_drain: begin
          re_q <= rdata_q[2*wDataIn-1:wDataIn];
          im_q <= rdata_q[wDataIn-1:0];
        end
        default: ;
      endcase
    end
  end

  assign source_valid = vld_q;
  assign source_sop = sop_q;
  assign source_eop = eop_q || abort_eop;
  assign source_real = re_q;
  assign source_imag = im_q;
  assign source_error = 2'b00;
  assign fftpts_out = n_q;
  assign frame_err = err_q;

`ifdef CE_SC_EXTRACT_FRMCNT_EN
  logic [15:0] fcnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n_sync) fcnt_q <= '0;
    else if (vld_q && source_ready && source_eop) fcnt_q <= fcnt_q + 16'd1;
  end

  assign frame_cnt = fcnt_q;
`endif

endmodule
